// File: rtl/psum_drain.sv
// PE-column sink: sums ACC_LEN valid partial sums into one result and queues
// completed results in a first-word fall-through FIFO for the readout path.
module psum_drain #(
    parameter int unsigned SUM_WIDTH  = 24,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ACC_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            i_valid,
    input  logic [SUM_WIDTH-1:0]            i_sum,
    input  logic                            i_clear,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [ACC_WIDTH-1:0]            o_data,
    output logic [$clog2(FIFO_DEPTH):0]     o_count,
    output logic                            o_busy,
    output logic                            o_overflow
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned BW   = $clog2(ACC_LEN + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [ACC_WIDTH-1:0]   sum_ext, result;
    logic                   push;

    logic [ACC_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [CNTW-1:0]        count_q;
    logic                   ovf_q;
    logic                   pop, full, accept, drop;

    assign sum_ext = ACC_WIDTH'(i_sum);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
        end
    end

    // The completing beat bypasses the accumulator and pushes acc+i_sum directly.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        push    = 1'b0;
        result  = ((state_q == IDLE) ? '0 : acc_q) + sum_ext;
        if (i_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            beat_d  = '0;
        end else if (i_valid) begin
            if (beat_q == BW'(ACC_LEN - 1)) begin
                push    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                beat_d  = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = result;
                beat_d  = beat_q + BW'(1);
            end
        end
    end

    assign pop    = (count_q != '0) && o_ready;
    assign full   = (count_q == CNTW'(FIFO_DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) wr_q <= wr_q + AW'(1);
            if (pop)    rd_q <= rd_q + AW'(1);
            count_q <= count_q + CNTW'(accept) - CNTW'(pop);
            if (i_clear)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[wr_q] <= result;
    end

    assign o_valid    = (count_q != '0);
    assign o_data     = o_valid ? mem[rd_q] : '0;
    assign o_count    = count_q;
    assign o_busy     = (beat_q != '0);
    assign o_overflow = ovf_q;

endmodule
